// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display path.
// Contents:
//   SEG_*  : 7-bit active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   CODE_* : 5-bit character codes for the non-hex glyphs
//   cap_state_e : lock-on FSM states of the scan capture block
// The display driver imports the same SEG_* constants, so both sides agree
// on what each glyph looks like.
package seg_pkg;

  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic [6:0] SEG_A      = 7'b0001000;
  localparam logic [6:0] SEG_B      = 7'b0000011;
  localparam logic [6:0] SEG_C      = 7'b1000110;
  localparam logic [6:0] SEG_D      = 7'b0100001;
  localparam logic [6:0] SEG_E      = 7'b0000110;
  localparam logic [6:0] SEG_F      = 7'b0001110;
  localparam logic [6:0] SEG_BLANK  = 7'b1111111;
  localparam logic [6:0] SEG_R      = 7'b0101111;
  localparam logic [6:0] SEG_DASH   = 7'b0111111;
  localparam logic [6:0] SEG_BAR_LO = 7'b1110111;
  localparam logic [6:0] SEG_BAR_HI = 7'b1111110;
  localparam logic [6:0] SEG_BOX_LO = 7'b0100011;
  localparam logic [6:0] SEG_BOX_HI = 7'b0011100;

  localparam logic [4:0] CODE_BLANK   = 5'h10;
  localparam logic [4:0] CODE_R       = 5'h11;
  localparam logic [4:0] CODE_DASH    = 5'h12;
  localparam logic [4:0] CODE_BAR_LO  = 5'h13;
  localparam logic [4:0] CODE_BAR_HI  = 5'h14;
  localparam logic [4:0] CODE_BOX_LO  = 5'h15;
  localparam logic [4:0] CODE_BOX_HI  = 5'h16;
  localparam logic [4:0] CODE_UNKNOWN = 5'h1F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    LOCKED = 2'd2
  } cap_state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to character-code lookup.
// Ports:
//   seg  : 7-bit active-low pattern {g,f,e,d,c,b,a}
//   code : 5-bit code (00h-0Fh hex digits, 10h-16h glyphs, 1Fh unknown)
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [4:0] code
);

  always_comb begin
    code = CODE_UNKNOWN;
    case (seg)
      SEG_0:      code = 5'h00;
      SEG_1:      code = 5'h01;
      SEG_2:      code = 5'h02;
      SEG_3:      code = 5'h03;
      SEG_4:      code = 5'h04;
      SEG_5:      code = 5'h05;
      SEG_6:      code = 5'h06;
      SEG_7:      code = 5'h07;
      SEG_8:      code = 5'h08;
      SEG_9:      code = 5'h09;
      SEG_A:      code = 5'h0A;
      SEG_B:      code = 5'h0B;
      SEG_C:      code = 5'h0C;
      SEG_D:      code = 5'h0D;
      SEG_E:      code = 5'h0E;
      SEG_F:      code = 5'h0F;
      SEG_BLANK:  code = CODE_BLANK;
      SEG_R:      code = CODE_R;
      SEG_DASH:   code = CODE_DASH;
      SEG_BAR_LO: code = CODE_BAR_LO;
      SEG_BAR_HI: code = CODE_BAR_HI;
      SEG_BOX_LO: code = CODE_BOX_LO;
      SEG_BOX_HI: code = CODE_BOX_HI;
      default:    code = CODE_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive-side capture of a multiplexed 7-segment display scan.
// Samples the active-low anode and segment buses, locks onto each digit once
// its pattern has been stable for STABLE_CYCLES samples, and rebuilds the
// full 8-digit frame in any scan order.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   disp_an[7:0] : anode select, active-low, bit k = digit k
//   disp_o[6:0]  : segments, active-low {g,f,e,d,c,b,a}
//   frame_seg    : raw patterns, digit k in [7k+6:7k]
//   frame_code   : decoded codes, digit k in [5k+4:5k]
//   frame_valid  : one-cycle pulse when frame_seg/frame_code update
//   frame_count  : completed frames, wraps at 2^16
//   scan_err     : one-cycle pulse per multi-anode sample
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  disp_an,
  input  logic [6:0]  disp_o,
  output logic [55:0] frame_seg,
  output logic [39:0] frame_code,
  output logic        frame_valid,
  output logic [15:0] frame_count,
  output logic        scan_err
);

  localparam logic [15:0] STABLE_N = 16'(STABLE_CYCLES);

  // Lowest-priority search is fine: only used when exactly one bit is low.
  function automatic logic [2:0] slot_of(input logic [7:0] an);
    slot_of = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (!an[k]) slot_of = 3'(k);
    end
  endfunction

  logic [7:0]       an_p0;
  logic [6:0]       seg_p0;
  cap_state_e       state_p1, state_nxt;
  logic [15:0]      cnt_p1, cnt_nxt;
  logic [2:0]       slot_p1, slot_nxt;
  logic [6:0]       pat_p1, pat_nxt;
  logic [7:0][6:0]  stage_p1;
  logic [7:0]       mask_p1, mask_acc;
  logic             vld_p1;
  logic [7:0][4:0]  code_w;
  logic             s_valid, s_blank, s_err, accept;
  logic [2:0]       s_slot;

  assign s_valid  = ($countones(~an_p0) == 1);
  assign s_blank  = &an_p0;
  assign s_err    = !s_valid && !s_blank;
  assign s_slot   = slot_of(an_p0);
  assign mask_acc = mask_p1 | (8'd1 << s_slot);

  // Lock-on FSM: cnt counts consecutive identical samples of the held slot.
  always_comb begin
    state_nxt = state_p1;
    cnt_nxt   = cnt_p1;
    slot_nxt  = slot_p1;
    pat_nxt   = pat_p1;
    accept    = 1'b0;
    if (!s_valid) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state_p1 != IDLE && s_slot == slot_p1 && seg_p0 == pat_p1) begin
      // LOCKED holds without re-accepting; COUNT advances towards acceptance.
      if (state_p1 == COUNT) begin
        cnt_nxt = cnt_p1 + 16'd1;
        if (cnt_nxt == STABLE_N) begin
          accept    = 1'b1;
          state_nxt = LOCKED;
        end
      end
    end else begin
      // New slot or new pattern: first sample of a fresh run.
      state_nxt = COUNT;
      cnt_nxt   = 16'd1;
      slot_nxt  = s_slot;
      pat_nxt   = seg_p0;
      if (STABLE_N == 16'd1) begin
        accept    = 1'b1;
        state_nxt = LOCKED;
      end
    end
  end

  for (genvar k = 0; k < 8; k++) begin : g_dec
    seg_decode u_dec (
      .seg  (stage_p1[k]),
      .code (code_w[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      an_p0       <= '1;
      seg_p0      <= '1;
      state_p1    <= IDLE;
      cnt_p1      <= '0;
      slot_p1     <= '0;
      pat_p1      <= '1;
      stage_p1    <= {8{SEG_BLANK}};
      mask_p1     <= '0;
      vld_p1      <= 1'b0;
      scan_err    <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      frame_seg   <= '1;
      frame_code  <= {8{CODE_BLANK}};
    end else begin
      // p0: pin sample
      an_p0    <= disp_an;
      seg_p0   <= disp_o;
      // p1: classification, lock-on and staging
      state_p1 <= state_nxt;
      cnt_p1   <= cnt_nxt;
      slot_p1  <= slot_nxt;
      pat_p1   <= pat_nxt;
      scan_err <= s_err;
      vld_p1   <= 1'b0;
      if (accept) begin
        stage_p1[s_slot] <= seg_p0;
        if (&mask_acc) begin
          mask_p1 <= '0;
          vld_p1  <= 1'b1;
        end else begin
          mask_p1 <= mask_acc;
        end
      end
      // p2: frame latch; staging here already holds the completing digit,
      // and any accept on this same edge only lands in staging afterwards.
      frame_valid <= vld_p1;
      if (vld_p1) begin
        frame_seg   <= stage_p1;
        frame_code  <= code_w;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  disp_an;
  logic [6:0]  disp_o;
  logic [55:0] fseg  [2];
  logic [39:0] fcode [2];
  logic        fv    [2];
  logic [15:0] fcnt  [2];
  logic        serr  [2];

  always #5 clk = ~clk;

  seg_scan_capture #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .disp_an(disp_an), .disp_o(disp_o),
    .frame_seg(fseg[0]), .frame_code(fcode[0]), .frame_valid(fv[0]),
    .frame_count(fcnt[0]), .scan_err(serr[0]));

  seg_scan_capture #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .disp_an(disp_an), .disp_o(disp_o),
    .frame_seg(fseg[1]), .frame_code(fcode[1]), .frame_valid(fv[1]),
    .frame_count(fcnt[1]), .scan_err(serr[1]));

  typedef struct {
    logic [6:0] seg;
    logic [4:0] code;
  } vec_t;
  vec_t tbl [24];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fv_pulses = 0;
  int err_pulses = 0;
  int first_fv_cyc = -1;

  // Reference model state: run length of identical valid samples per instance,
  // staged digits, coverage mask, and a two-sample delay to the frame outputs.
  int              NS [2] = '{4, 1};
  int              run [2];
  logic [7:0]      prv_an;
  logic [6:0]      prv_seg;
  logic [7:0][6:0] stg [2];
  logic [7:0]      mask [2];
  bit              fv1 [2], fv2 [2];
  logic [55:0]     snap1 [2], snap2 [2];
  logic [55:0]     exp_frame [2];
  logic [15:0]     exp_count [2];
  bit              err1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [4:0] ref_code(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h1F;
    for (int j = 0; j < 23; j++) if (tbl[j].seg == s) r = tbl[j].code;
    return r;
  endfunction

  function automatic logic [39:0] codes_of(input logic [55:0] f);
    logic [39:0] r;
    for (int k = 0; k < 8; k++) r[5*k +: 5] = ref_code(f[7*k +: 7]);
    return r;
  endfunction

  task automatic model_reset();
    err1 = 1'b0; prv_an = '1; prv_seg = '1;
    for (int i = 0; i < 2; i++) begin
      run[i] = 0; stg[i] = '1; mask[i] = '0;
      fv1[i] = 1'b0; fv2[i] = 1'b0; snap1[i] = '1; snap2[i] = '1;
      exp_frame[i] = '1; exp_count[i] = '0;
    end
  endtask

  // One clock: drive pins (and reset) after the falling edge, advance the
  // model, then compare every output 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [7:0] an, input logic [6:0] sg);
    bit exp_err;
    bit exp_fv [2];
    int nz, k;
    bit valid;
    @(negedge clk);
    rst_n = r; disp_an = an; disp_o = sg;
    nz = $countones(~an);
    valid = (nz == 1);
    k = 0;
    for (int b = 0; b < 8; b++) if (!an[b]) k = b;
    if (!r) begin
      model_reset();
      exp_err = 1'b0; exp_fv[0] = 1'b0; exp_fv[1] = 1'b0;
    end else begin
      exp_err = err1;
      err1 = (nz >= 2);
      for (int i = 0; i < 2; i++) begin
        bit c;
        logic [55:0] snap;
        if (valid && an == prv_an && sg == prv_seg) run[i]++;
        else run[i] = valid ? 1 : 0;
        c = 1'b0; snap = '1;
        if (valid && run[i] == NS[i]) begin
          stg[i][k] = sg;
          mask[i][k] = 1'b1;
          if (&mask[i]) begin c = 1'b1; snap = stg[i]; mask[i] = '0; end
        end
        exp_fv[i] = fv2[i];
        if (fv2[i]) begin exp_frame[i] = snap2[i]; exp_count[i] = exp_count[i] + 16'd1; end
        fv2[i] = fv1[i]; snap2[i] = snap1[i]; fv1[i] = c; snap1[i] = snap;
      end
      prv_an = an; prv_seg = sg;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("scan_err[%0d]", i), serr[i], exp_err);
      chk($sformatf("frame_valid[%0d]", i), fv[i], exp_fv[i]);
      chk($sformatf("frame_seg[%0d]", i), fseg[i], exp_frame[i]);
      chk($sformatf("frame_code[%0d]", i), fcode[i], codes_of(exp_frame[i]));
      chk($sformatf("frame_count[%0d]", i), fcnt[i], exp_count[i]);
    end
    if (fv[0] === 1'b1) begin
      fv_pulses++;
      if (first_fv_cyc < 0) first_fv_cyc = cyc;
    end
    if (serr[0] === 1'b1) err_pulses++;
  endtask

  task automatic scan_digit(input int k, input logic [6:0] pat, input int dwell);
    repeat (dwell) step(1'b1, ~(8'd1 << k), pat);
  endtask

  task automatic do_reset();
    repeat (2) step(1'b0, 8'hFF, 7'h7F);
  endtask

  logic [6:0] msg [8];
  int p0, e0, n0;
  logic [7:0] r_an;
  logic [6:0] r_sg;
  int r_t, r_d;

  initial begin
    tbl[0]  = '{7'b1000000, 5'h00}; tbl[1]  = '{7'b1111001, 5'h01};
    tbl[2]  = '{7'b0100100, 5'h02}; tbl[3]  = '{7'b0110000, 5'h03};
    tbl[4]  = '{7'b0011001, 5'h04}; tbl[5]  = '{7'b0010010, 5'h05};
    tbl[6]  = '{7'b0000010, 5'h06}; tbl[7]  = '{7'b1111000, 5'h07};
    tbl[8]  = '{7'b0000000, 5'h08}; tbl[9]  = '{7'b0010000, 5'h09};
    tbl[10] = '{7'b0001000, 5'h0A}; tbl[11] = '{7'b0000011, 5'h0B};
    tbl[12] = '{7'b1000110, 5'h0C}; tbl[13] = '{7'b0100001, 5'h0D};
    tbl[14] = '{7'b0000110, 5'h0E}; tbl[15] = '{7'b0001110, 5'h0F};
    tbl[16] = '{7'b1111111, 5'h10}; tbl[17] = '{7'b0101111, 5'h11};
    tbl[18] = '{7'b0111111, 5'h12}; tbl[19] = '{7'b1110111, 5'h13};
    tbl[20] = '{7'b1111110, 5'h14}; tbl[21] = '{7'b0100011, 5'h15};
    tbl[22] = '{7'b0011100, 5'h16}; tbl[23] = '{7'b1010101, 5'h1F};

    rst_n = 1'b0; disp_an = 8'hFF; disp_o = 7'h7F;
    model_reset();

    // Reset values
    repeat (3) step(1'b0, 8'hFF, 7'h7F);
    for (int i = 0; i < 2; i++) begin
      chk("rst_seg", fseg[i], 56'hFF_FFFF_FFFF_FFFF);
      chk("rst_code", fcode[i], {8{5'h10}});
      chk("rst_fv", fv[i], 1'b0);
      chk("rst_cnt", fcnt[i], 16'd0);
      chk("rst_err", serr[i], 1'b0);
    end

    // Idle bus for 10k cycles
    p0 = fv_pulses;
    repeat (10000) step(1'b1, 8'hFF, 7'h7F);
    chk("blank_seg", fseg[0], 56'hFF_FFFF_FFFF_FFFF);
    chk("blank_code", fcode[0], {8{5'h10}});
    chk("blank_cnt", fcnt[0], 16'd0);
    chk("blank_fv_pulses", fv_pulses - p0, 0);

    // "  10Err " : digit0..7 = blank, r, r, E, 0, 1, blank, blank
    do_reset();
    msg[0] = 7'h7F; msg[1] = 7'h2F; msg[2] = 7'h2F; msg[3] = 7'h06;
    msg[4] = 7'h40; msg[5] = 7'h79; msg[6] = 7'h7F; msg[7] = 7'h7F;
    p0 = fv_pulses;
    for (int k = 0; k < 8; k++) scan_digit(k, msg[k], 10);
    chk("10err_pulses", fv_pulses - p0, 1);
    chk("10err_code", fcode[0],
        {5'h10, 5'h10, 5'h01, 5'h00, 5'h0E, 5'h11, 5'h11, 5'h10});
    chk("10err_cnt", fcnt[0], 16'd1);

    // Dwell shorter than the lock threshold
    p0 = fv_pulses;
    repeat (2) for (int k = 0; k < 8; k++) scan_digit(k, tbl[$urandom_range(0, 22)].seg, 3);
    chk("dwell3_pulses", fv_pulses - p0, 0);
    chk("dwell3_cnt", fcnt[0], 16'd1);

    // Multi-anode glitch splits digit 2's run: 2 + 3 samples never lock
    do_reset();
    p0 = fv_pulses; e0 = err_pulses;
    scan_digit(2, 7'h40, 2);
    step(1'b1, 8'b11101110, 7'h40);
    scan_digit(2, 7'h40, 3);
    for (int k = 0; k < 8; k++) if (k != 2) scan_digit(k, 7'h79, 10);
    chk("err_pulses", err_pulses - e0, 1);
    chk("err_no_frame", fv_pulses - p0, 0);
    scan_digit(2, 7'h40, 10);
    chk("err_then_frame", fv_pulses - p0, 1);

    // Glitchy segments on digit 5 before settling on "7"
    do_reset();
    for (int k = 0; k < 8; k++) if (k != 5) scan_digit(k, 7'h40, 10);
    for (int j = 0; j < 10; j++) scan_digit(5, j[0] ? 7'h19 : 7'h30, 2);
    first_fv_cyc = -1;
    p0 = fv_pulses;
    n0 = cyc + 1;
    scan_digit(5, 7'h78, 10);
    chk("glitch_pulses", fv_pulses - p0, 1);
    chk("glitch_code5", fcode[0][29:25], 5'h07);
    chk("glitch_seg5", fseg[0][41:35], 7'h78);
    chk("glitch_latency", first_fv_cyc - n0, 5);

    // Reset after five accepted digits discards them
    do_reset();
    for (int k = 0; k < 5; k++) scan_digit(k, 7'h12, 10);
    do_reset();
    p0 = fv_pulses;
    for (int k = 5; k < 8; k++) scan_digit(k, 7'h24, 10);
    chk("rstmid_partial", fv_pulses - p0, 0);
    for (int k = 0; k < 5; k++) scan_digit(k, 7'h24, 10);
    chk("rstmid_pulses", fv_pulses - p0, 1);
    chk("rstmid_cnt", fcnt[0], 16'd1);

    // Table-driven decode over three frames
    do_reset();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 8; k++) scan_digit(k, tbl[f*8 + k].seg, 10);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("tbl_code[%0d]", f*8 + k), fcode[0][5*k +: 5], tbl[f*8 + k].code);
        chk($sformatf("tbl_code1[%0d]", f*8 + k), fcode[1][5*k +: 5], tbl[f*8 + k].code);
      end
    end

    // Randomized scan: slots, blanks, multi-anode errors, varying dwell
    do_reset();
    repeat (3000) begin
      r_t = $urandom_range(0, 9);
      if (r_t < 8)       r_an = ~(8'd1 << $urandom_range(0, 7));
      else if (r_t == 8) r_an = 8'hFF;
      else               r_an = 8'($urandom);
      r_sg = tbl[$urandom_range(0, 23)].seg;
      r_d = $urandom_range(1, 7);
      repeat (r_d) step(1'b1, r_an, r_sg);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side companion to the multiplexed 7-segment display driver. It samples the active-low anode-select bus and segment bus, locks onto each digit slot once its pattern has been stable, and rebuilds the full 8-digit frame. It also decodes each digit into a character code and pulses when a complete frame has been assembled. It serves as a loopback checker on the board and as a scoreboard front end in simulation.

## Interface
- STABLE_CYCLES, 1024: consecutive identical samples required before a digit is accepted (range 1..65535).
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- disp_an  in  8  anode select, active-low, one-hot expected; bit k = digit k.
- disp_o  in  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- frame_seg  out  56  captured raw patterns, digit k in bits [7k+6:7k].
- frame_code  out  40  decoded codes, digit k in bits [5k+4:5k].
- frame_valid  out  1  one-cycle pulse; frame_seg/frame_code just updated.
- frame_count  out  16  number of frames completed, wraps at 2^16.
- scan_err  out  1  one-cycle pulse on each multi-anode sample.

## Operation
- Input stage: disp_an and disp_o are registered once (sample S). All decisions use S.
- Slot classification of S:
  - exactly one anode bit 0 → valid slot k;
  - all ones → blank;
  - two or more zeros → error; scan_err pulses that cycle.
- FSM, states IDLE, COUNT, LOCKED:
  - IDLE: valid slot → COUNT, cnt=1, remember slot k and pattern p.
  - COUNT: same k and p → cnt+1. When cnt reaches STABLE_CYCLES → accept, go LOCKED. Different p, same k → cnt=1, p updated. Different valid k → restart COUNT on the new slot. Blank or error → IDLE.
  - LOCKED: same k and p → stay, no further accepts. Same k, new p → COUNT, cnt=1. Different valid k → COUNT. Blank or error → IDLE.
- With STABLE_CYCLES=1, acceptance happens on the first sample and the FSM goes directly to LOCKED.
- Accept: staging entry k ← p; pending mask bit k ← 1. Re-accepting an already-set digit overwrites its staging entry.
- Frame completion: the accept that makes the pending mask all ones triggers the following next cycle:
  - frame_seg ← staging with the new entry included;
  - frame_code ← decode of each entry;
  - frame_valid=1 for one cycle;
  - frame_count+1;
  - mask cleared.
- Scan order is irrelevant; only coverage of all 8 digits counts.
- Decode (pattern → code):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9;
  - 0001000→A, 0000011→B, 1000110→C, 0100001→D, 0000110→E, 0001110→F;
  - 1111111→10h (blank), 0101111→11h (r), 0111111→12h (dash), 1110111→13h (low bar), 1111110→14h (top bar), 0100011→15h (lower box), 0011100→16h (upper box);
  - anything else →1Fh.

## Timing
- Reset values: frame_seg all ones (blank); frame_code 10h in every digit; frame_valid 0; frame_count 0; scan_err 0. FSM goes to IDLE, mask clears, cnt=0, staging entries are all ones.
- Latency: a pin change reaches S after 1 cycle. The accept happens on the cycle cnt hits STABLE_CYCLES. frame_valid is asserted on the next clock edge after that accept.
- scan_err is asserted 1 cycle after the offending pin sample, i.e. registered off S.
- Reset asserted mid-frame discards all staged digits. A partial frame never produces frame_valid.
- frame_count wraps FFFFh→0000h without side effects.
- A frame completion and a new slot arriving on the same cycle: the completion uses the old staging data; the new slot starts COUNT normally.

## Structure
- Package seg_pkg holds:
  - the 7-bit segment constants (SEG_0..SEG_F, SEG_BLANK, SEG_R, SEG_DASH, SEG_BAR_LO, SEG_BAR_HI, SEG_BOX_LO, SEG_BOX_HI);
  - the 5-bit code constants (CODE_BLANK=10h … CODE_UNKNOWN=1Fh);
  - the FSM state enum.
- The display driver should import the same segment constants.
- Sub-module seg_decode: combinational 7→5 lookup, instantiated 8× at frame latch.

## Test plan
- Reset, then hold inputs all ones for 10k cycles → frame_seg all ones, frame_code 10h×8, no frame_valid, frame_count=0.
- STABLE_CYCLES=4; scan digits 0..7, 10 cycles each, with the pattern for "  10Err " (digit7..0: blank, blank, 1, 0, E, r, r, blank) → exactly one frame_valid; frame_code digit7..0 = 10h,10h,01h,00h,0Eh,11h,11h,10h; frame_count=1.
- Dwell of 3 cycles per digit with STABLE_CYCLES=4 → no accepts, no frame_valid ever.
- disp_an=8'b11101110 for one cycle mid-scan → scan_err pulses once. FSM goes to IDLE, and the current digit restarts its count.
- Glitchy segments (pattern toggles every 2 cycles for 20 cycles, then steady) → accepted value is the steady pattern, STABLE_CYCLES after it settles.
- Assert rst_n=0 after 5 digits accepted, release, scan all 8 → frame_valid only after all 8 are re-accepted; frame_count=1.
